// File: rtl/snake_video_pkg.sv
// ---------------------------------------------------------------------------
// snake_video_pkg
// Shared definitions for the snake video receive path:
//   - colour constants in {B,G,R} order (WHITE / BLACK / GRAY)
//   - default 800x600 grid geometry (origin 160/60, 30-pixel cells, 16x16)
//   - capture FSM state encoding
//   - saturating increment helper for the 12-bit position counters
// ---------------------------------------------------------------------------
package snake_video_pkg;

  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] BLACK = 24'h000000;
  localparam logic [23:0] GRAY  = 24'h646464;

  localparam int H_RES_DEF   = 800;
  localparam int V_RES_DEF   = 600;
  localparam int GRID_X0_DEF = 160;
  localparam int GRID_Y0_DEF = 60;
  localparam int CELL_DEF    = 30;
  localparam int GRID_N      = 16;
  localparam int MAP_W       = GRID_N * GRID_N;
  localparam int CNT_W       = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] cnt_inc_sat(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/snake_video_grid_capture_pos_counter.sv
// ---------------------------------------------------------------------------
// snake_video_grid_capture_pos_counter (module snake_video_pos_counter)
// Input register stage and raster position tracking.
// Ports:
//   I_pxl_clk, I_rst_n   pixel clock, asynchronous active-low reset
//   I_de, I_vs, I_color  raw video inputs
//   de_q, color_q        DE / colour delayed by one register stage
//   vs_start             1-cycle strobe: registered VS became active
//   de_fall              1-cycle strobe: registered DE went 1 -> 0
//   h_cnt                0-based index of the current DE-high pixel
//   v_cnt                number of DE falling edges since VS start
// Parameter VS_POL selects the active level of I_vs.
// ---------------------------------------------------------------------------
module snake_video_pos_counter
  import snake_video_pkg::*;
#(
  parameter bit VS_POL = 1'b1
) (
  input  logic             I_pxl_clk,
  input  logic             I_rst_n,
  input  logic             I_de,
  input  logic             I_vs,
  input  logic [23:0]      I_color,
  output logic             de_q,
  output logic [23:0]      color_q,
  output logic             vs_start,
  output logic             de_fall,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt
);

  logic de_d_reg;
  logic vs_act_reg;
  logic vs_act_d_reg;

  assign vs_start = vs_act_reg & ~vs_act_d_reg;
  assign de_fall  = de_d_reg & ~de_q;

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      de_q         <= 1'b0;
      color_q      <= '0;
      vs_act_reg   <= 1'b0;
      vs_act_d_reg <= 1'b0;
      de_d_reg     <= 1'b0;
      h_cnt        <= '0;
      v_cnt        <= '0;
    end else begin
      de_q         <= I_de;
      color_q      <= I_color;
      // Polarity is folded in here so everything downstream sees active-high.
      vs_act_reg   <= (I_vs == VS_POL);
      vs_act_d_reg <= vs_act_reg;
      de_d_reg     <= de_q;

      // h_cnt equals the pixel index while de_q is high for that pixel.
      if (de_q)
        h_cnt <= cnt_inc_sat(h_cnt);
      else if (de_fall)
        h_cnt <= '0;

      if (vs_start)
        v_cnt <= '0;
      else if (de_fall)
        v_cnt <= cnt_inc_sat(v_cnt);
    end
  end

endmodule

// File: rtl/snake_video_grid_capture.sv
// ---------------------------------------------------------------------------
// snake_video_grid_capture
// Rebuilds the 16x16 snake map from the rendered pixel stream by sampling
// the centre pixel of every grid cell and committing the map once per
// complete frame.
// Ports:
//   I_pxl_clk, I_rst_n  pixel clock, asynchronous active-low reset
//   I_en                capture enable (level)
//   I_de, I_hs, I_vs    video timing (I_hs unused: lines come from DE)
//   I_color             pixel colour {B,G,R}
//   O_map               row r = O_map[r*16 +: 16], bit 15 = leftmost cell
//   O_frame_done        1-cycle pulse when O_map is updated
//   O_busy              high in WAIT_VS and CAPTURE
//   O_short_frame       1-cycle pulse when a frame is cut short by VS
//   O_color_err         sticky per frame, sample was neither black nor white
// Build option: define SNAKE_CAP_COLOR_CHECK_EN for strict black/white
// decoding with colour error reporting; otherwise a cell is "snake" when
// its green channel is below 128 and O_color_err stays 0.
// ---------------------------------------------------------------------------
module snake_video_grid_capture
  import snake_video_pkg::*;
#(
  parameter int H_RES   = H_RES_DEF,
  parameter int V_RES   = V_RES_DEF,
  parameter int GRID_X0 = GRID_X0_DEF,
  parameter int GRID_Y0 = GRID_Y0_DEF,
  parameter int CELL    = CELL_DEF,
  parameter bit VS_POL  = 1'b1
) (
  input  logic             I_pxl_clk,
  input  logic             I_rst_n,
  input  logic             I_en,
  input  logic             I_de,
  input  logic             I_hs,
  input  logic             I_vs,
  input  logic [23:0]      I_color,
  output logic [MAP_W-1:0] O_map,
  output logic             O_frame_done,
  output logic             O_busy,
  output logic             O_short_frame,
  output logic             O_color_err
);

  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_RES - 1);
  localparam logic [CNT_W-1:0] V_END  = CNT_W'(V_RES);

  logic             de_q;
  logic [23:0]      color_q;
  logic             vs_start;
  logic             de_fall;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  snake_video_pos_counter #(
    .VS_POL (VS_POL)
  ) u_pos (
    .I_pxl_clk (I_pxl_clk),
    .I_rst_n   (I_rst_n),
    .I_de      (I_de),
    .I_vs      (I_vs),
    .I_color   (I_color),
    .de_q      (de_q),
    .color_q   (color_q),
    .vs_start  (vs_start),
    .de_fall   (de_fall),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt)
  );

  // -------------------------------------------------------------------------
  // Cell-centre match. Centres falling outside the active area can never be
  // reached, so they are tied off at elaboration.
  // -------------------------------------------------------------------------
  logic [GRID_N-1:0] col_hit;
  logic [GRID_N-1:0] row_hit;
  logic [MAP_W-1:0]  wr_mask;

  genvar gi, gj;
  generate
    for (gi = 0; gi < GRID_N; gi++) begin : g_hit
      localparam int COL_POS = GRID_X0 + gi * CELL + CELL / 2;
      localparam int ROW_POS = GRID_Y0 + gi * CELL + CELL / 2;
      if (COL_POS < H_RES) begin : g_col
        assign col_hit[gi] = (h_cnt == CNT_W'(COL_POS));
      end else begin : g_col_off
        assign col_hit[gi] = 1'b0;
      end
      if (ROW_POS < V_RES) begin : g_row
        assign row_hit[gi] = (v_cnt == CNT_W'(ROW_POS));
      end else begin : g_row_off
        assign row_hit[gi] = 1'b0;
      end
    end

    // Column 0 is the leftmost cell and lands on bit 15 of its row.
    for (gi = 0; gi < GRID_N; gi++) begin : g_mask_row
      for (gj = 0; gj < GRID_N; gj++) begin : g_mask_col
        assign wr_mask[gi*GRID_N + (GRID_N-1-gj)] = row_hit[gi] & col_hit[gj];
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Colour decode
  // -------------------------------------------------------------------------
  logic sample_bit;
  logic unused_in;

`ifdef SNAKE_CAP_COLOR_CHECK_EN
  logic sample_bad;
  assign sample_bit = (color_q == BLACK);
  assign sample_bad = (color_q != BLACK) && (color_q != WHITE);
  assign unused_in  = I_hs;
`else
  assign sample_bit = ~color_q[15];
  assign unused_in  = ^{I_hs, color_q[23:16], color_q[14:0]};
`endif

  // -------------------------------------------------------------------------
  // Control
  // -------------------------------------------------------------------------
  cap_state_t       state_reg;
  logic [MAP_W-1:0] shadow_reg;
  logic [MAP_W-1:0] map_reg;
  logic             frame_done_reg;
  logic             busy_reg;
  logic             short_frame_reg;

  logic short_restart;
  logic cap_entry;
  logic sample_en;

  // A VS start inside CAPTURE means the previous frame was incomplete; it is
  // treated like a fresh entry so the shadow map starts clean.
  assign short_restart = (state_reg == CAPTURE) && vs_start && (v_cnt < V_END);
  assign cap_entry     = ((state_reg == WAIT_VS) && vs_start) || short_restart;
  assign sample_en     = (state_reg == CAPTURE) && de_q;

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_reg       <= IDLE;
      map_reg         <= '0;
      frame_done_reg  <= 1'b0;
      busy_reg        <= 1'b0;
      short_frame_reg <= 1'b0;
    end else begin
      frame_done_reg  <= 1'b0;
      short_frame_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (I_en) begin
            state_reg <= WAIT_VS;
            busy_reg  <= 1'b1;
          end
        end
        WAIT_VS: begin
          if (vs_start)
            state_reg <= CAPTURE;
        end
        CAPTURE: begin
          if (short_restart) begin
            short_frame_reg <= 1'b1;
          end else if (de_fall && (v_cnt == V_LAST)) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
          end
        end
        DONE: begin
          map_reg        <= shadow_reg;
          frame_done_reg <= 1'b1;
          if (I_en) begin
            state_reg <= WAIT_VS;
            busy_reg  <= 1'b1;
          end else begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n)
      shadow_reg <= '0;
    else if (cap_entry)
      shadow_reg <= '0;
    else if (sample_en)
      shadow_reg <= (shadow_reg & ~wr_mask) | (wr_mask & {MAP_W{sample_bit}});
  end

`ifdef SNAKE_CAP_COLOR_CHECK_EN
  logic color_err_reg;
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n)
      color_err_reg <= 1'b0;
    else if (cap_entry)
      color_err_reg <= 1'b0;
    else if (sample_en && (|wr_mask) && sample_bad)
      color_err_reg <= 1'b1;
  end
  assign O_color_err = color_err_reg;
`else
  assign O_color_err = 1'b0;
`endif

  assign O_map         = map_reg;
  assign O_frame_done  = frame_done_reg;
  assign O_busy        = busy_reg;
  assign O_short_frame = short_frame_reg;

endmodule
